// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - posted-write FIFO between DataMemory and backing memory
// Acks writes immediately, drains them in order, forwards reads from the youngest buffered copy.
module mem_write_buffer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            up_addr,
  input  logic                         up_read_en,
  input  logic                         up_write_en,
  input  logic [DATA_W-1:0]            up_write_val,
  output logic [DATA_W-1:0]            up_read_val,
  output logic                         up_response,
  output logic [ADDR_W-1:0]            dn_addr,
  output logic                         dn_read_en,
  output logic                         dn_write_en,
  output logic [DATA_W-1:0]            dn_write_val,
  input  logic [DATA_W-1:0]            dn_read_val,
  input  logic                         dn_response,
  output logic [$clog2(DEPTH+1)-1:0]   buf_count,
  output logic                         buf_empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {UP_IDLE, UP_RESP, UP_WAITRD} up_state_t;
  typedef enum logic [1:0] {DN_IDLE, DN_WR, DN_RD} dn_state_t;

  up_state_t          up_state_q;
  dn_state_t          dn_state_q;
  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  up_read_val_q;
  logic               up_response_q;
  logic               miss_pend_q;
  logic [ADDR_W-1:0]  miss_addr_q;
  logic [ADDR_W-1:0]  dn_addr_q;
  logic               dn_read_en_q, dn_write_en_q;
  logic [DATA_W-1:0]  dn_write_val_q;

  logic               pop, push, can_push, rd_done;
  logic               hit;
  logic [DATA_W-1:0]  hit_data;
  logic [PTR_W-1:0]   idx;

  assign pop      = (dn_state_q == DN_WR) && dn_response;
  assign rd_done  = (dn_state_q == DN_RD) && dn_response;
  // A full FIFO still accepts a write on the edge the head drains.
  assign can_push = (count_q != CNT_W'(DEPTH)) || pop;
  assign push     = (up_state_q == UP_IDLE) && up_write_en && can_push;

  // Scan oldest to youngest so the last match left standing is the youngest copy.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[idx] == up_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= up_addr;
      data_q[wr_ptr_q] <= up_write_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      up_state_q    <= UP_IDLE;
      up_response_q <= 1'b0;
      up_read_val_q <= '0;
      miss_pend_q   <= 1'b0;
      miss_addr_q   <= '0;
    end else begin
      up_response_q <= 1'b0;
      case (up_state_q)
        UP_IDLE: begin
          if (up_write_en) begin
            if (can_push) begin
              up_response_q <= 1'b1;
              up_state_q    <= UP_RESP;
            end
          end else if (up_read_en) begin
            if (hit) begin
              up_read_val_q <= hit_data;
              up_response_q <= 1'b1;
              up_state_q    <= UP_RESP;
            end else begin
              miss_pend_q <= 1'b1;
              miss_addr_q <= up_addr;
              up_state_q  <= UP_WAITRD;
            end
          end
        end
        UP_RESP: up_state_q <= UP_IDLE;
        UP_WAITRD: begin
          if (rd_done) begin
            up_read_val_q <= dn_read_val;
            up_response_q <= 1'b1;
            miss_pend_q   <= 1'b0;
            up_state_q    <= UP_RESP;
          end
        end
        default: up_state_q <= UP_IDLE;
      endcase
    end
  end

  // A pending miss means no buffered copy exists, so serving it before draining is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_state_q     <= DN_IDLE;
      dn_addr_q      <= '0;
      dn_read_en_q   <= 1'b0;
      dn_write_en_q  <= 1'b0;
      dn_write_val_q <= '0;
    end else begin
      case (dn_state_q)
        DN_IDLE: begin
          if (miss_pend_q) begin
            dn_addr_q    <= miss_addr_q;
            dn_read_en_q <= 1'b1;
            dn_state_q   <= DN_RD;
          end else if (count_q != '0) begin
            dn_addr_q      <= addr_q[rd_ptr_q];
            dn_write_val_q <= data_q[rd_ptr_q];
            dn_write_en_q  <= 1'b1;
            dn_state_q     <= DN_WR;
          end
        end
        DN_WR: begin
          if (dn_response) begin
            dn_write_en_q <= 1'b0;
            dn_state_q    <= DN_IDLE;
          end
        end
        DN_RD: begin
          if (dn_response) begin
            dn_read_en_q <= 1'b0;
            dn_state_q   <= DN_IDLE;
          end
        end
        default: dn_state_q <= DN_IDLE;
      endcase
    end
  end

  assign up_read_val  = up_read_val_q;
  assign up_response  = up_response_q;
  assign dn_addr      = dn_addr_q;
  assign dn_read_en   = dn_read_en_q;
  assign dn_write_en  = dn_write_en_q;
  assign dn_write_val = dn_write_val_q;
  assign buf_count    = count_q;
  assign buf_empty    = (count_q == '0);
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb/tb_mem_write_buffer.sv - directed vector bench for mem_write_buffer
module tb_mem_write_buffer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] up_addr = '0;
  logic        up_read_en = 1'b0;
  logic        up_write_en = 1'b0;
  logic [31:0] up_write_val = '0;
  logic [31:0] up_read_val;
  logic        up_response;
  logic [31:0] dn_addr;
  logic        dn_read_en, dn_write_en;
  logic [31:0] dn_write_val;
  logic [31:0] dn_read_val;
  logic        dn_response;
  logic [2:0]  buf_count;
  logic        buf_empty;

  mem_write_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_addr(up_addr), .up_read_en(up_read_en), .up_write_en(up_write_en),
    .up_write_val(up_write_val), .up_read_val(up_read_val), .up_response(up_response),
    .dn_addr(dn_addr), .dn_read_en(dn_read_en), .dn_write_en(dn_write_en),
    .dn_write_val(dn_write_val), .dn_read_val(dn_read_val), .dn_response(dn_response),
    .buf_count(buf_count), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Backing-memory model: fixed latency, optional stall, logs every write it completes.
  int          lat = 3;
  bit          stall = 1'b0;
  int          wcnt = 0;
  int          resp_cnt = 0;
  int          wr_resp_cyc = 0, rd_resp_cyc = 0, rd_rise_cyc = 0;
  bit          prev_rd = 1'b0, rd_ever = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] log_a [$];
  logic [31:0] log_d [$];

  initial begin
    dn_response = 1'b0;
    dn_read_val = '0;
    mem[32'h20] = 32'h55;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        dn_response = 1'b0;
        wcnt = 0;
        prev_rd = 1'b0;
      end else begin
        if (dn_read_en && !prev_rd) rd_rise_cyc = cyc;
        if (dn_read_en) rd_ever = 1'b1;
        prev_rd = dn_read_en;
        if (dn_response) begin
          dn_response = 1'b0;
        end else if ((dn_write_en || dn_read_en) && !stall) begin
          wcnt++;
          if (wcnt >= lat) begin
            wcnt = 0;
            dn_response = 1'b1;
            resp_cnt++;
            if (dn_write_en) begin
              mem[dn_addr] = dn_write_val;
              log_a.push_back(dn_addr);
              log_d.push_back(dn_write_val);
              wr_resp_cyc = cyc;
            end else begin
              dn_read_val = mem.exists(dn_addr) ? mem[dn_addr] : 32'h0;
              rd_resp_cyc = cyc;
            end
          end
        end
      end
    end
  end

  task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                        output int n, output logic [31:0] rv, output int at_cyc);
    up_addr = a;
    up_write_val = d;
    up_write_en = wr;
    up_read_en = !wr;
    n = -1;
    rv = '0;
    at_cyc = 0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk);
      #1;
      if (up_response) begin
        n = k;
        rv = up_read_val;
        at_cyc = cyc;
        break;
      end
    end
    up_write_en = 1'b0;
    up_read_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (buf_empty && !dn_write_en && !dn_read_en) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("settle", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          stall;
    bit          settle;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rval;
    int          exp_cnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int          n, at, base, base_resp;
    logic [31:0] rv;
    bit          bad;

    tbl[0] = '{1'b1, 1'b0, 1'b1, 32'h4,  32'h1,  1, 32'h0,  1};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'h4,  32'h2,  1, 32'h0,  2};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h4,  32'h0,  1, 32'h2,  2};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 32'h8,  32'h33, 1, 32'h0,  3};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h8,  32'h0,  1, 32'h33, 3};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h4,  32'h0,  1, 32'h2,  3};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h10, 32'hAA, 1, 32'h0,  1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h10, 32'h0,  5, 32'hAA, 0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h0,  5, 32'h55, 0};

    #1;
    check("rst_up_response", 32'(up_response), 32'd0);
    check("rst_dn_write_en", 32'(dn_write_en), 32'd0);
    check("rst_dn_read_en", 32'(dn_read_en), 32'd0);
    check("rst_buf_count", 32'(buf_count), 32'd0);
    check("rst_buf_empty", 32'(buf_empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      if (i == 6) begin
        check("hit_no_dn_read", 32'(rd_ever), 32'd0);
        check("drain_pending", 32'(log_a.size()), 32'd0);
      end
      stall = tbl[i].stall;
      if (tbl[i].settle) settle();
      do_req(tbl[i].wr, tbl[i].addr, tbl[i].wdata, n, rv, at);
      check($sformatf("v%0d_latency", i), 32'(n), 32'(tbl[i].exp_lat));
      if (!tbl[i].wr) check($sformatf("v%0d_read_val", i), rv, tbl[i].exp_rval);
      check($sformatf("v%0d_buf_count", i), 32'(buf_count), 32'(tbl[i].exp_cnt));
    end
    check("tbl_log_size", 32'(log_a.size()), 32'd4);
    check("tbl_log0", {log_a[0][15:0], log_d[0][15:0]}, 32'h0004_0001);
    check("tbl_log1", {log_a[1][15:0], log_d[1][15:0]}, 32'h0004_0002);
    check("tbl_log2", {log_a[2][15:0], log_d[2][15:0]}, 32'h0008_0033);
    check("tbl_log3", {log_a[3][15:0], log_d[3][15:0]}, 32'h0010_00AA);

    // Full FIFO: fifth write waits for the first drain, count stays at DEPTH.
    settle();
    stall = 1'b1;
    for (int j = 0; j < 4; j++) begin
      do_req(1'b1, 32'h40 + 32'(4*j), 32'h200 + 32'(j), n, rv, at);
      check($sformatf("fill%0d_latency", j), 32'(n), 32'd1);
      check($sformatf("fill%0d_count", j), 32'(buf_count), 32'(j+1));
    end
    base = log_a.size();
    base_resp = resp_cnt;
    up_addr = 32'h50;
    up_write_val = 32'h300;
    up_write_en = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (up_response || buf_count != 3'd4) bad = 1'b1;
    end
    check("full_blocked", 32'(bad), 32'd0);
    stall = 1'b0;
    n = -1;
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk);
      #1;
      if (up_response) begin
        n = k;
        break;
      end
    end
    check("full_accept_seen", 32'(n > 0), 32'd1);
    check("full_accept_after_drain", 32'(resp_cnt), 32'(base_resp + 1));
    check("full_accept_count", 32'(buf_count), 32'd4);
    up_write_en = 1'b0;
    @(posedge clk);
    #1;
    settle();
    check("full_log_size", 32'(log_a.size()), 32'(base + 5));
    for (int j = 0; j < 5; j++) begin
      check($sformatf("full_log%0d_addr", j), log_a[base+j], (j < 4) ? 32'h40 + 32'(4*j) : 32'h50);
      check($sformatf("full_log%0d_data", j), log_d[base+j], (j < 4) ? 32'h200 + 32'(j) : 32'h300);
    end

    // Read miss arriving while a write drains waits for that write.
    base = cyc;
    do_req(1'b1, 32'h30, 32'h77, n, rv, at);
    check("miss_wr_latency", 32'(n), 32'd1);
    do_req(1'b0, 32'h20, 32'h0, n, rv, at);
    check("miss_read_val", rv, 32'h55);
    check("miss_wr_done_in_test", 32'(wr_resp_cyc > base), 32'd1);
    check("miss_rd_after_wr", 32'(rd_rise_cyc > wr_resp_cyc), 32'd1);
    check("miss_resp_timing", 32'(at), 32'(rd_resp_cyc + 1));

    // 2*DEPTH+1 writes wrap the pointers and drain in order.
    settle();
    base = log_a.size();
    for (int j = 0; j < 9; j++) begin
      do_req(1'b1, 32'(j), 32'(100 + j), n, rv, at);
      check($sformatf("wrap%0d_acked", j), 32'(n > 0), 32'd1);
    end
    settle();
    check("wrap_log_size", 32'(log_a.size()), 32'(base + 9));
    for (int j = 0; j < 9; j++) begin
      check($sformatf("wrap_log%0d", j), {log_a[base+j][15:0], log_d[base+j][15:0]},
            {16'(j), 16'(100 + j)});
    end
    check("wrap_buf_empty", 32'(buf_empty), 32'd1);

    // Reset while a write is held downstream.
    stall = 1'b1;
    do_req(1'b1, 32'h60, 32'h1, n, rv, at);
    check("rstmid_latency", 32'(n), 32'd1);
    check("rstmid_dn_wr_active", 32'(dn_write_en), 32'd1);
    check("rstmid_dn_addr", dn_addr, 32'h60);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_dn_write_en", 32'(dn_write_en), 32'd0);
    check("rstmid_buf_count", 32'(buf_count), 32'd0);
    check("rstmid_buf_empty", 32'(buf_empty), 32'd1);
    check("rstmid_dn_addr0", dn_addr, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (up_response || dn_write_en || dn_read_en) bad = 1'b1;
    end
    check("rstmid_quiet_after", 32'(bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
